// File: rtl/sparse_cnn_pkg.sv
// Shared types for the sparse CNN partial-sum datapath: FSM state encoding,
// the wide accumulator type and the signed saturation limits.
package sparse_cnn_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int ACC_MAX_W = 64;
    typedef logic signed [ACC_MAX_W-1:0] acc_t;

    function automatic acc_t sat_max(input int w);
        return (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    endfunction

    function automatic acc_t sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: sign-extends a DATA_W addend onto an ACC_W
// accumulator and clamps the result to the signed ACC_W range.
module sat_add
    import sparse_cnn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [DATA_W-1:0] addend,
    output logic signed [ACC_W-1:0]  sum
);

    // One guard bit above the wider operand means the raw sum can never wrap.
    localparam int SUM_W = ((ACC_W > DATA_W) ? ACC_W : DATA_W) + 1;
    localparam logic signed [SUM_W-1:0] HI = SUM_W'(sat_max(ACC_W));
    localparam logic signed [SUM_W-1:0] LO = SUM_W'(sat_min(ACC_W));

    logic signed [SUM_W-1:0] wide;

    assign wide = SUM_W'(acc) + SUM_W'(addend);

    always_comb begin
        sum = ACC_W'(wide);
        if (wide > HI) begin
            sum = ACC_W'(HI);
        end else if (wide < LO) begin
            sum = ACC_W'(LO);
        end
    end

endmodule

// File: rtl/sparse_psum_accum.sv
// Accumulates sparse (row, col, psum) triples from NUM_CH channels into an
// OUT_SIZE x OUT_SIZE map, then streams it out. SPARSE_PSUM_RELU_EN clamps negatives on drain.
module sparse_psum_accum
    import sparse_cnn_pkg::*;
#(
    parameter int OUT_SIZE = 24,
    parameter int DATA_W   = 16,
    parameter int COORD_W  = 8,
    parameter int NUM_CH   = 4,
    parameter int ACC_W    = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [COORD_W-1:0]       in_row,
    input  logic [COORD_W-1:0]       in_col,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     coord_err,
    output state_t                   state_dbg
);

    localparam int NPTS  = OUT_SIZE * OUT_SIZE;
    localparam int IDX_W = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [CH_W-1:0]          ch_cnt;
    logic                     err_q;
    logic signed [ACC_W-1:0]  mem [NPTS];

    logic                     coord_ok;
    logic                     accept;
    logic [IDX_W-1:0]         pt_addr;
    logic signed [ACC_W-1:0]  cur_val;
    logic signed [ACC_W-1:0]  sum_val;
    logic signed [ACC_W-1:0]  drain_val;

    // Both ports use plain valid/ready: a beat transfers on a rising edge
    // where valid and ready are both high; the FSM state alone drives ready/valid.
    assign accept   = in_valid && in_ready;
    assign coord_ok = (32'(in_row) < 32'(OUT_SIZE)) && (32'(in_col) < 32'(OUT_SIZE));
    assign pt_addr  = IDX_W'(32'(in_row) * 32'(OUT_SIZE) + 32'(in_col));
    assign cur_val  = coord_ok ? mem[pt_addr] : '0;

    sat_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .acc    (cur_val),
        .addend (in_data),
        .sum    (sum_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_CLEAR) begin
                mem[idx] <= '0;
            end else if (accept && coord_ok) begin
                mem[pt_addr] <= sum_val;
            end
        end
    end

    // idx walks the map twice per frame: once zeroing in CLEAR, once reading in DRAIN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_CLEAR;
            idx    <= '0;
            ch_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (idx == LAST_IDX) begin
                        idx    <= '0;
                        ch_cnt <= '0;
                        state  <= ST_ACCUM;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        if (!coord_ok) begin
                            err_q <= 1'b1;
                        end
                        if (in_last) begin
                            if (ch_cnt == LAST_CH) begin
                                ch_cnt <= '0;
                                state  <= ST_DRAIN;
                            end else begin
                                ch_cnt <= ch_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ST_CLEAR;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign drain_val = mem[idx];

`ifdef SPARSE_PSUM_RELU_EN
    assign out_data = (out_valid && !drain_val[ACC_W-1]) ? drain_val : '0;
`else
    assign out_data = out_valid ? drain_val : '0;
`endif

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DRAIN);
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign busy      = !((state == ST_ACCUM) && (ch_cnt == '0));
    assign coord_err = err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_sparse_psum_accum.sv
// Bench for sparse_psum_accum: two instances (4 channels / 24-bit acc and
// 1 channel / 8-bit acc) checked against a per-point arithmetic map model.
module tb_sparse_psum_accum;
    import sparse_cnn_pkg::*;

    localparam int SIDE = 24;
    localparam int N    = SIDE * SIDE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic              in_valid [2];
    logic              in_last  [2];
    logic              out_ready[2];
    logic signed [15:0] in_data [2];
    logic [7:0]        in_row   [2];
    logic [7:0]        in_col   [2];

    logic in_ready_a, out_valid_a, out_last_a, busy_a, coord_err_a;
    logic in_ready_b, out_valid_b, out_last_b, busy_b, coord_err_b;
    logic signed [23:0] out_data_a;
    logic signed [7:0]  out_data_b;
    state_t st_a, st_b;

    sparse_psum_accum #(.OUT_SIZE(24), .DATA_W(16), .COORD_W(8), .NUM_CH(4), .ACC_W(24)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready_a), .in_data(in_data[0]),
        .in_row(in_row[0]), .in_col(in_col[0]), .in_last(in_last[0]),
        .out_valid(out_valid_a), .out_ready(out_ready[0]), .out_data(out_data_a),
        .out_last(out_last_a), .busy(busy_a), .coord_err(coord_err_a), .state_dbg(st_a)
    );

    sparse_psum_accum #(.OUT_SIZE(24), .DATA_W(16), .COORD_W(8), .NUM_CH(1), .ACC_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready_b), .in_data(in_data[1]),
        .in_row(in_row[1]), .in_col(in_col[1]), .in_last(in_last[1]),
        .out_valid(out_valid_b), .out_ready(out_ready[1]), .out_data(out_data_b),
        .out_last(out_last_b), .busy(busy_b), .coord_err(coord_err_b), .state_dbg(st_b)
    );

    // Reference model: one integer per map point, channel count and sticky error.
    int  model [2][N];
    int  ch_m  [2];
    bit  cerr_m[2];
    logic [31:0] exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    function automatic int accw(int w);   return (w == 0) ? 24 : 8; endfunction
    function automatic int nch(int w);    return (w == 0) ? 4 : 1; endfunction
    function automatic logic rdy(int w);    return (w == 0) ? in_ready_a  : in_ready_b;  endfunction
    function automatic logic ovalid(int w); return (w == 0) ? out_valid_a : out_valid_b; endfunction
    function automatic logic olast(int w);  return (w == 0) ? out_last_a  : out_last_b;  endfunction
    function automatic logic obusy(int w);  return (w == 0) ? busy_a      : busy_b;      endfunction
    function automatic logic oerr(int w);   return (w == 0) ? coord_err_a : coord_err_b; endfunction
    function automatic int odata(int w);
        return (w == 0) ? int'(out_data_a) : int'(out_data_b);
    endfunction

    function automatic int clamp(int v, int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int drained(int v);
        int r = v;
`ifdef SPARSE_PSUM_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < N; i++) model[w][i] = 0;
            ch_m[w]   = 0;
            cerr_m[w] = 1'b0;
        end
    endtask

    task automatic wait_clear(input int w, input int exp_cycles);
        int cnt = 0;
        int bad = 0;
        while (!rdy(w) && cnt < 2000) begin
            if (ovalid(w)) bad++;
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt !== exp_cycles) begin
            n_fail++;
            $display("FAIL clear_len dut%0d: got %0d cycles, expected %0d", w, cnt, exp_cycles);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL clear_out_valid dut%0d: out_valid high on %0d cycles, expected 0", w, bad);
        end
    endtask

    task automatic send(input int w, input int d, input int r, input int c, input bit last);
        int  cnt = 0;
        bit  fin = 1'b0;
        while (!rdy(w) && cnt < 2000) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (!rdy(w)) begin
            n_fail++;
            $display("FAIL send_ready_timeout dut%0d: in_ready got 0, expected 1", w);
            return;
        end
        in_valid[w] = 1'b1;
        in_data[w]  = 16'(d);
        in_row[w]   = 8'(r);
        in_col[w]   = 8'(c);
        in_last[w]  = last;
        tick();
        in_valid[w] = 1'b0;
        in_last[w]  = 1'b0;
        if (r < SIDE && c < SIDE) model[w][r*SIDE+c] = clamp(model[w][r*SIDE+c] + d, accw(w));
        else cerr_m[w] = 1'b1;
        if (last) begin
            ch_m[w]++;
            if (ch_m[w] == nch(w)) begin
                fin     = 1'b1;
                ch_m[w] = 0;
            end
        end
        n_checks++;
        if (oerr(w) !== cerr_m[w]) begin
            n_fail++;
            $display("FAIL coord_err dut%0d: got %0b expected %0b", w, oerr(w), cerr_m[w]);
        end
        n_checks++;
        if (ovalid(w) !== fin) begin
            n_fail++;
            $display("FAIL out_valid_latency dut%0d: got %0b expected %0b", w, ovalid(w), fin);
        end
        n_checks++;
        if (rdy(w) !== !fin) begin
            n_fail++;
            $display("FAIL in_ready_after dut%0d: got %0b expected %0b", w, rdy(w), !fin);
        end
        n_checks++;
        if (obusy(w) !== (fin || ch_m[w] != 0)) begin
            n_fail++;
            $display("FAIL busy dut%0d: got %0b expected %0b", w, obusy(w), (fin || ch_m[w] != 0));
        end
    endtask

    // mode 0: random out_ready, mode 1: strict 1/0 toggle.
    task automatic drain(input int w, input int mode);
        int k = 0;
        int cyc = 0;
        bit tog = 1'b1;
        bit rr;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(32'(drained(model[w][i])));
            model[w][i] = 0;
        end
        while (exp_q.size() > 0 && cyc < 5000) begin
            rr  = (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            out_ready[w] = rr;
            n_checks++;
            if (ovalid(w) !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_valid dut%0d idx %0d: got %0b expected 1", w, k, ovalid(w));
            end
            n_checks++;
            if (odata(w) !== int'(exp_q[0])) begin
                n_fail++;
                $display("FAIL drain_data dut%0d idx %0d: got %0d expected %0d", w, k, odata(w), int'(exp_q[0]));
            end
            n_checks++;
            if (olast(w) !== (exp_q.size() == 1)) begin
                n_fail++;
                $display("FAIL drain_last dut%0d idx %0d: got %0b expected %0b", w, k, olast(w), exp_q.size() == 1);
            end
            tick();
            cyc++;
            if (rr) begin
                void'(exp_q.pop_front());
                k++;
            end
        end
        out_ready[w] = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout dut%0d: got %0d points, expected %0d", w, k, N);
        end
        n_checks++;
        if (ovalid(w) !== 1'b0 || rdy(w) !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_exit dut%0d: got valid %0b ready %0b, expected 0 0", w, ovalid(w), rdy(w));
        end
        wait_clear(w, N);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int w = 0; w < 2; w++) begin
            in_valid[w] = 1'b0; in_last[w] = 1'b0; out_ready[w] = 1'b0;
            in_data[w] = '0; in_row[w] = '0; in_col[w] = '0;
        end
        clear_model();
        repeat (3) tick();
        for (int pass = 0; pass < 2; pass++) begin
            for (int w = 0; w < 2; w++) begin
                n_checks++;
                if (rdy(w) !== 1'b0 || ovalid(w) !== 1'b0 || olast(w) !== 1'b0 ||
                    odata(w) !== 0 || obusy(w) !== 1'b1 || oerr(w) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_outputs dut%0d pass %0d: got rdy %0b vld %0b last %0b data %0d busy %0b err %0b, expected 0 0 0 0 1 0",
                             w, pass, rdy(w), ovalid(w), olast(w), odata(w), obusy(w), oerr(w));
                end
            end
            n_checks++;
            if (st_a !== ST_CLEAR) begin
                n_fail++;
                $display("FAIL reset_state: got %0d expected %0d", st_a, ST_CLEAR);
            end
            rst = 1'b1;
        end
        wait_clear(0, N);
        n_checks++;
        if (rdy(1) !== 1'b1 || obusy(0) !== 1'b0) begin
            n_fail++;
            $display("FAIL accum_entry: got rdy_b %0b busy_a %0b, expected 1 0", rdy(1), obusy(0));
        end
    endtask

    task automatic test_num_ch1_basic();
        send(1, 5, 0, 0, 1'b0);
        send(1, 3, 0, 0, 1'b0);
        send(1, -2, 23, 23, 1'b1);
        drain(1, 0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) send(1, 100, 0, 0, i == 3);
        drain(1, 0);
        for (int i = 0; i < 4; i++) send(1, -100, 0, 0, i == 3);
        drain(1, 0);
        for (int i = 0; i < 12; i++)
            send(1, $urandom_range(0, 240) - 120, 5, $urandom_range(0, 2), i == 11);
        drain(1, 1);
    endtask

    task automatic test_four_channels();
        for (int ch = 0; ch < 4; ch++) send(0, 100, 1, 1, 1'b1);
        drain(0, 1);
    endtask

    task automatic test_coord_err();
        send(0, 55, 24, 3, 1'b0);
        send(0, -7, 2, 2, 1'b0);
        send(0, 9, 3, 30, 1'b1);
        for (int ch = 1; ch < 4; ch++) send(0, 0, 0, 0, 1'b1);
        drain(0, 0);
    endtask

    task automatic test_back_to_back();
        for (int ch = 0; ch < 4; ch++) begin
            int n = $urandom_range(5, 20);
            for (int i = 0; i < n; i++) begin
                int r = ($urandom_range(0, 3) == 0) ? 7 : $urandom_range(0, 25);
                int c = ($urandom_range(0, 3) == 0) ? 7 : $urandom_range(0, 25);
                int d = int'($signed(16'($urandom_range(0, 65535))));
                send(0, d, r, c, i == n - 1);
            end
        end
        drain(0, 0);
    endtask

    task automatic test_reset_mid_drain();
        send(0, 50, 4, 4, 1'b1);
        send(0, -20, 0, 1, 1'b1);
        send(0, 0, 0, 0, 1'b1);
        send(0, 0, 0, 0, 1'b1);
        out_ready[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if (odata(0) !== drained(model[0][i]) || ovalid(0) !== 1'b1) begin
                n_fail++;
                $display("FAIL partial_drain idx %0d: got %0d valid %0b, expected %0d valid 1",
                         i, odata(0), ovalid(0), drained(model[0][i]));
            end
            tick();
        end
        out_ready[0] = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        clear_model();
        n_checks++;
        if (rdy(0) !== 1'b0 || ovalid(0) !== 1'b0 || oerr(0) !== 1'b0 || obusy(0) !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got rdy %0b vld %0b err %0b busy %0b, expected 0 0 0 1",
                     rdy(0), ovalid(0), oerr(0), obusy(0));
        end
        rst = 1'b1;
        wait_clear(0, N);
        send(0, -3, 10, 10, 1'b1);
        send(0, 11, 0, 5, 1'b1);
        send(0, 0, 0, 0, 1'b1);
        send(0, 0, 0, 0, 1'b1);
        drain(0, 0);
    endtask

    initial begin
        test_reset();
        test_num_ch1_basic();
        test_saturation();
        test_four_channels();
        test_coord_err();
        test_back_to_back();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sparse_psum_accum.md
SPARSE_PSUM_ACCUM -- requirements
Module: sparse_psum_accum

Interface
REQ-001 SHALL have parameter OUT_SIZE, default 24, meaning output feature map side length (map holds OUT_SIZE*OUT_SIZE points).
REQ-002 SHALL have parameter DATA_W, default 16, meaning signed partial-sum width from the PE.
REQ-003 SHALL have parameter COORD_W, default 8, meaning row/col coordinate width.
REQ-004 SHALL have parameter NUM_CH, default 4, meaning input channels accumulated per output map.
REQ-005 SHALL have parameter ACC_W, default 24, meaning signed accumulator and output width.
REQ-006 SHALL have ports clk (input, 1, sole clock, rising edge) and rst (input, 1, synchronous active-low reset).
REQ-007 SHALL have in_valid (input, 1, triple valid), in_ready (output, 1, triple accepted when in_valid and in_ready are both high), in_data (input, DATA_W, signed partial sum), in_row (input, COORD_W, row), in_col (input, COORD_W, column), in_last (input, 1, final triple of current channel).
REQ-008 SHALL have out_valid (output, 1), out_ready (input, 1), out_data (output, ACC_W, signed map point), out_last (output, 1, final point of map).
REQ-009 SHALL have busy (output, 1, high in every state except ACCUM with zero channels accepted) and coord_err (output, 1, sticky out-of-range flag).

Function
REQ-010 SHALL implement states CLEAR, ACCUM and DRAIN.
REQ-011 CLEAR SHALL zero one buffer entry per cycle in raster order with in_ready=0, and SHALL enter ACCUM after OUT_SIZE*OUT_SIZE cycles with the channel counter at 0.
REQ-012 ACCUM SHALL hold in_ready=1, and each accepted triple SHALL update buf[in_row*OUT_SIZE+in_col] with the sign-extended in_data added, visible to the next cycle's access (back-to-back hits on the same address accumulate correctly).
REQ-013 Addition SHALL saturate to the signed ACC_W range (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)).
REQ-014 A triple with in_row>=OUT_SIZE or in_col>=OUT_SIZE SHALL be accepted but not written, and SHALL set coord_err until reset; in_last on such a triple still counts.
REQ-015 An accepted triple with in_last=1 SHALL increment the channel counter; when the counter equals NUM_CH-1 at that acceptance, the FSM SHALL enter DRAIN on the next cycle.
REQ-016 A channel with no nonzero data SHALL be signalled by a triple with in_data=0 and in_last=1.
REQ-017 DRAIN SHALL hold in_ready=0 and out_valid=1, present buf[idx] on out_data starting at idx 0, hold out_data stable while out_ready=0, and advance idx on each handshake.
REQ-018 out_last SHALL be high exactly when idx=OUT_SIZE*OUT_SIZE-1; the handshake at that point SHALL return the FSM to CLEAR.
REQ-019 Output latency SHALL be: first out_valid on the cycle after the final in_last acceptance.

Reset
REQ-020 While rst=0 on a clock edge: state to CLEAR, clear index 0, channel counter 0, idx 0, coord_err 0.
REQ-021 Outputs while rst=0 and on the first cycle after release: in_ready=0, out_valid=0, out_last=0, out_data=0, busy=1.
REQ-022 Reset asserted mid-ACCUM or mid-DRAIN SHALL abandon the map and restart with a full CLEAR pass.

Configuration
REQ-023 With SPARSE_PSUM_RELU_EN defined, DRAIN SHALL output 0 for every negative buffer value.
REQ-024 Without SPARSE_PSUM_RELU_EN, DRAIN SHALL output buffer values unmodified.

Structure
REQ-025 State encoding, accumulator type and saturation limits SHALL live in a shared package sparse_cnn_pkg.
REQ-026 Saturating add SHALL be a sub-module sat_add (DATA_W + ACC_W in, ACC_W out); the buffer SHALL be inline register storage.

Verification
REQ-027 Reset release: in_ready=0 for 576 cycles (OUT_SIZE=24), then 1; out_valid stays 0.
REQ-028 NUM_CH=1: triples (5,0,0),(3,0,0),(-2,23,23,last) -> drain gives out_data[0]=8, out_data[575]=-2 with out_last, all others 0.
REQ-029 NUM_CH=4: +100 at (1,1) per channel, each with last -> out_data[25]=400; out_ready toggled 1/0 keeps data stable while stalled.
REQ-030 ACC_W=8: four +100 at (0,0) -> out_data[0]=127; four -100 -> -128.
REQ-031 Triple at row 24 -> coord_err=1, buffer unchanged; with SPARSE_PSUM_RELU_EN a -7 point drains as 0.
REQ-032 rst=0 at drain idx 100 -> next map drains all zeros except new data.
